// File: rtl/recarbit_if.sv
// Bus between the write demux / LLC side and the receive-arbitration access controller.
// The master drives requests; the slave (controller) drives the register strobes and status.
interface recarbit_if;
  logic        cpu_wr;
  logic        cpu_sel;
  logic [15:0] cpu_data;
  logic        prom;
  logic        can_req;
  logic [15:0] can_id_hi;
  logic [15:0] can_id_lo;
  logic        ovr_clr;
  logic        cpu1;
  logic        cpu2;
  logic        can1;
  logic        can2;
  logic [15:0] reginp;
  logic [15:0] recidin;
  logic        cpu_busy;
  logic        can_done;
  logic        cpu_ovr;
  logic        can_lost;

  modport master (
    output cpu_wr, cpu_sel, cpu_data, prom, can_req, can_id_hi, can_id_lo, ovr_clr,
    input  cpu1, cpu2, can1, can2, reginp, recidin, cpu_busy, can_done, cpu_ovr, can_lost
  );

  modport slave (
    input  cpu_wr, cpu_sel, cpu_data, prom, can_req, can_id_hi, can_id_lo, ovr_clr,
    output cpu1, cpu2, can1, can2, reginp, recidin, cpu_busy, can_done, cpu_ovr, can_lost
  );
endinterface

// File: rtl/recarbit_ctrl.sv
// Serialises CPU writes and two-word LLC identifier captures onto the receive
// arbitration register pair, alternating service so neither side starves.
module recarbit_ctrl (
  input  logic      clk,
  input  logic      rst,
  recarbit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU_W, CAN_W1, CAN_W2} state_t;

  state_t      state_reg, state_next;

  logic        cpu_v_reg;
  logic        cpu_sel_reg;
  logic [15:0] cpu_data_reg;
  logic        can_v_reg;
  logic [15:0] hi_reg;
  logic [15:0] lo_reg;
  logic [15:0] lo_stage_reg;

  logic        cpu1_reg, cpu2_reg, can1_reg, can2_reg;
  logic [15:0] reginp_reg, recidin_reg;
  logic        cpu_busy_reg, can_done_reg, cpu_ovr_reg, can_lost_reg;

  logic        cpu_acc, cpu_drop, cpu_pend;
  logic        can_in, can_pend, can_take, cpu_take, can_drop, can_store;
  logic        sel_take;
  logic [15:0] data_take, hi_take, lo_take;

  always_comb begin
    cpu_acc  = bus.cpu_wr & ~cpu_v_reg;
    cpu_drop = bus.cpu_wr & cpu_v_reg;
    cpu_pend = cpu_v_reg | bus.cpu_wr;
    can_in   = bus.prom & bus.can_req;
    can_pend = can_v_reg | can_in;

    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = cpu_pend ? CPU_W  : (can_pend ? CAN_W1 : IDLE);
      CPU_W:   state_next = can_pend ? CAN_W1 : (cpu_pend ? CPU_W  : IDLE);
      CAN_W1:  state_next = CAN_W2;
      CAN_W2:  state_next = cpu_pend ? CPU_W  : (can_pend ? CAN_W1 : IDLE);
      default: state_next = IDLE;
    endcase

    cpu_take  = (state_next == CPU_W);
    can_take  = (state_next == CAN_W1);
    // A capture arriving while the buffered one is being consumed takes its slot.
    can_drop  = can_in & can_v_reg & ~can_take;
    can_store = can_in & (~can_v_reg | can_take);

    sel_take  = cpu_v_reg ? cpu_sel_reg  : bus.cpu_sel;
    data_take = cpu_v_reg ? cpu_data_reg : bus.cpu_data;
    hi_take   = can_v_reg ? hi_reg       : bus.can_id_hi;
    lo_take   = can_v_reg ? lo_reg       : bus.can_id_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cpu_v_reg    <= 1'b0;
      cpu_sel_reg  <= 1'b0;
      cpu_data_reg <= 16'h0000;
      can_v_reg    <= 1'b0;
      hi_reg       <= 16'h0000;
      lo_reg       <= 16'h0000;
      lo_stage_reg <= 16'h0000;
      cpu1_reg     <= 1'b0;
      cpu2_reg     <= 1'b0;
      can1_reg     <= 1'b0;
      can2_reg     <= 1'b0;
      reginp_reg   <= 16'h0000;
      recidin_reg  <= 16'h0000;
      cpu_busy_reg <= 1'b0;
      can_done_reg <= 1'b0;
      cpu_ovr_reg  <= 1'b0;
      can_lost_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (cpu_take) begin
        cpu_v_reg <= 1'b0;
      end else if (cpu_acc) begin
        cpu_v_reg    <= 1'b1;
        cpu_sel_reg  <= bus.cpu_sel;
        cpu_data_reg <= bus.cpu_data;
      end

      if (can_take) begin
        can_v_reg    <= can_v_reg & can_in;
        lo_stage_reg <= lo_take;
      end else if (can_in) begin
        can_v_reg <= 1'b1;
      end
      if (can_store) begin
        hi_reg <= bus.can_id_hi;
        lo_reg <= bus.can_id_lo;
      end

      cpu1_reg     <= cpu_take & ~sel_take;
      cpu2_reg     <= cpu_take & sel_take;
      can1_reg     <= can_take;
      can2_reg     <= (state_next == CAN_W2);
      can_done_reg <= (state_next == CAN_W2);
      if (cpu_take)
        reginp_reg <= data_take;
      if (can_take)
        recidin_reg <= hi_take;
      else if (state_next == CAN_W2)
        recidin_reg <= lo_stage_reg;

      cpu_busy_reg <= (cpu_v_reg | cpu_acc) & ~cpu_take;
      // A new drop in the clearing cycle wins over the clear.
      cpu_ovr_reg  <= (cpu_ovr_reg & ~bus.ovr_clr) | cpu_drop;
      can_lost_reg <= (can_lost_reg & ~bus.ovr_clr) | can_drop;
    end
  end

  assign bus.cpu1     = cpu1_reg;
  assign bus.cpu2     = cpu2_reg;
  assign bus.can1     = can1_reg;
  assign bus.can2     = can2_reg;
  assign bus.reginp   = reginp_reg;
  assign bus.recidin  = recidin_reg;
  assign bus.cpu_busy = cpu_busy_reg;
  assign bus.can_done = can_done_reg;
  assign bus.cpu_ovr  = cpu_ovr_reg;
  assign bus.can_lost = can_lost_reg;

endmodule

// File: tb/tb_recarbit_ctrl.sv
// Directed bench for recarbit_ctrl: each task drives one scenario and checks
// the registered outputs one cycle at a time against hand-computed values.
module tb_recarbit_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  recarbit_if bus ();

  recarbit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_wr    = 1'b0;
    bus.cpu_sel   = 1'b0;
    bus.cpu_data  = 16'h0000;
    bus.can_req   = 1'b0;
    bus.can_id_hi = 16'h0000;
    bus.can_id_lo = 16'h0000;
    bus.ovr_clr   = 1'b0;
  endtask

  task automatic cpu_req(input logic sel, input logic [15:0] data);
    bus.cpu_wr   = 1'b1;
    bus.cpu_sel  = sel;
    bus.cpu_data = data;
  endtask

  task automatic can_cap(input logic [15:0] hi, input logic [15:0] lo);
    bus.can_req   = 1'b1;
    bus.can_id_hi = hi;
    bus.can_id_lo = lo;
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    clear_inputs();
    bus.prom = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    flags = {bus.cpu1, bus.cpu2, bus.can1, bus.can2, bus.cpu_busy, bus.can_done, bus.cpu_ovr, bus.can_lost, 2'b00};
    checks++; if (flags !== 10'd0) begin errors++; $display("FAIL reset_flags got %b want 0", flags); end
    checks++; if (bus.reginp !== 16'h0000 || bus.recidin !== 16'h0000) begin errors++; $display("FAIL reset_data got %h/%h want 0000/0000", bus.reginp, bus.recidin); end
    rst = 1'b1;
    tick();
    // Reset lands while CAN_W1 is on the strobes.
    bus.prom = 1'b1;
    can_cap(16'h1111, 16'h2222);
    tick();
    clear_inputs();
    checks++; if (bus.can1 !== 1'b1) begin errors++; $display("FAIL reset_pre_can1 got %b want 1", bus.can1); end
    rst = 1'b0;
    tick();
    flags = {bus.cpu1, bus.cpu2, bus.can1, bus.can2, bus.cpu_busy, bus.can_done, bus.cpu_ovr, bus.can_lost, 2'b00};
    checks++; if (flags !== 10'd0) begin errors++; $display("FAIL reset_abort_flags got %b want 0", flags); end
    checks++; if (bus.recidin !== 16'h0000) begin errors++; $display("FAIL reset_abort_recidin got %h want 0000", bus.recidin); end
    rst = 1'b1;
    tick();
    checks++; if (bus.can2 !== 1'b0) begin errors++; $display("FAIL reset_no_can2 got %b want 0", bus.can2); end
    cpu_req(1'b0, 16'h5555);
    tick();
    clear_inputs();
    checks++; if (bus.cpu1 !== 1'b1 || bus.reginp !== 16'h5555) begin errors++; $display("FAIL reset_first_cpu got cpu1=%b reginp=%h want 1/5555", bus.cpu1, bus.reginp); end
    tick();
    checks++; if (bus.cpu1 !== 1'b0 || bus.reginp !== 16'h5555) begin errors++; $display("FAIL reset_cpu_hold got cpu1=%b reginp=%h want 0/5555", bus.cpu1, bus.reginp); end
  endtask

  task automatic test_cpu_write();
    cpu_req(1'b1, 16'hA5A5);
    tick();
    clear_inputs();
    checks++; if ({bus.cpu1, bus.cpu2, bus.cpu_busy} !== 3'b010) begin errors++; $display("FAIL cpu_strobe got cpu1/cpu2/busy=%b want 010", {bus.cpu1, bus.cpu2, bus.cpu_busy}); end
    checks++; if (bus.reginp !== 16'hA5A5) begin errors++; $display("FAIL cpu_data got %h want a5a5", bus.reginp); end
    tick();
    checks++; if ({bus.cpu1, bus.cpu2, bus.cpu_busy} !== 3'b000) begin errors++; $display("FAIL cpu_after got cpu1/cpu2/busy=%b want 000", {bus.cpu1, bus.cpu2, bus.cpu_busy}); end
    checks++; if (bus.reginp !== 16'hA5A5) begin errors++; $display("FAIL cpu_hold got %h want a5a5", bus.reginp); end
  endtask

  task automatic test_llc_capture();
    bus.prom = 1'b1;
    can_cap(16'h1234, 16'hABCD);
    tick();
    clear_inputs();
    checks++; if ({bus.can1, bus.can2, bus.can_done} !== 3'b100 || bus.recidin !== 16'h1234) begin errors++; $display("FAIL llc_w1 got can1/can2/done=%b recidin=%h want 100/1234", {bus.can1, bus.can2, bus.can_done}, bus.recidin); end
    tick();
    checks++; if ({bus.can1, bus.can2, bus.can_done} !== 3'b011 || bus.recidin !== 16'hABCD) begin errors++; $display("FAIL llc_w2 got can1/can2/done=%b recidin=%h want 011/abcd", {bus.can1, bus.can2, bus.can_done}, bus.recidin); end
    tick();
    checks++; if ({bus.can1, bus.can2, bus.can_done} !== 3'b000 || bus.recidin !== 16'hABCD) begin errors++; $display("FAIL llc_idle got can1/can2/done=%b recidin=%h want 000/abcd", {bus.can1, bus.can2, bus.can_done}, bus.recidin); end
  endtask

  task automatic test_simultaneous();
    cpu_req(1'b0, 16'h0F0F);
    can_cap(16'h0BAD, 16'hCAFE);
    tick();
    clear_inputs();
    checks++; if ({bus.cpu1, bus.can1, bus.can2, bus.cpu_busy} !== 4'b1000 || bus.reginp !== 16'h0F0F) begin errors++; $display("FAIL sim_n1 got cpu1/can1/can2/busy=%b reginp=%h want 1000/0f0f", {bus.cpu1, bus.can1, bus.can2, bus.cpu_busy}, bus.reginp); end
    tick();
    checks++; if ({bus.cpu1, bus.can1, bus.can2, bus.cpu_busy} !== 4'b0100 || bus.recidin !== 16'h0BAD) begin errors++; $display("FAIL sim_n2 got cpu1/can1/can2/busy=%b recidin=%h want 0100/0bad", {bus.cpu1, bus.can1, bus.can2, bus.cpu_busy}, bus.recidin); end
    tick();
    checks++; if ({bus.cpu1, bus.can1, bus.can2, bus.cpu_busy} !== 4'b0010 || bus.recidin !== 16'hCAFE) begin errors++; $display("FAIL sim_n3 got cpu1/can1/can2/busy=%b recidin=%h want 0010/cafe", {bus.cpu1, bus.can1, bus.can2, bus.cpu_busy}, bus.recidin); end
    tick();
    checks++; if ({bus.cpu1, bus.can1, bus.can2, bus.cpu_busy} !== 4'b0000) begin errors++; $display("FAIL sim_n4 got cpu1/can1/can2/busy=%b want 0000", {bus.cpu1, bus.can1, bus.can2, bus.cpu_busy}); end
  endtask

  task automatic test_atomicity();
    can_cap(16'h1357, 16'h2468);
    tick();
    clear_inputs();
    // CAN_W1 on the strobes now: a CPU write must wait behind CAN_W2.
    cpu_req(1'b1, 16'h1111);
    tick();
    clear_inputs();
    checks++; if ({bus.can2, bus.cpu1, bus.cpu2, bus.cpu_busy} !== 4'b1001) begin errors++; $display("FAIL atom_w2 got can2/cpu1/cpu2/busy=%b want 1001", {bus.can2, bus.cpu1, bus.cpu2, bus.cpu_busy}); end
    cpu_req(1'b0, 16'h2222);
    tick();
    clear_inputs();
    checks++; if ({bus.cpu1, bus.cpu2, bus.cpu_busy, bus.cpu_ovr} !== 4'b0101 || bus.reginp !== 16'h1111) begin errors++; $display("FAIL atom_cpu got cpu1/cpu2/busy/ovr=%b reginp=%h want 0101/1111", {bus.cpu1, bus.cpu2, bus.cpu_busy, bus.cpu_ovr}, bus.reginp); end
    tick();
    checks++; if ({bus.cpu1, bus.cpu2, bus.cpu_busy} !== 3'b000 || bus.reginp !== 16'h1111) begin errors++; $display("FAIL atom_dropped got cpu1/cpu2/busy=%b reginp=%h want 000/1111", {bus.cpu1, bus.cpu2, bus.cpu_busy}, bus.reginp); end
    bus.ovr_clr = 1'b1;
    tick();
    clear_inputs();
    checks++; if (bus.cpu_ovr !== 1'b0) begin errors++; $display("FAIL atom_ovr_clr got %b want 0", bus.cpu_ovr); end
  endtask

  task automatic test_drops();
    bus.prom = 1'b0;
    can_cap(16'hDEAD, 16'hBEEF);
    tick();
    clear_inputs();
    tick();
    checks++; if ({bus.can1, bus.can2, bus.can_lost} !== 3'b000) begin errors++; $display("FAIL prom_off got can1/can2/lost=%b want 000", {bus.can1, bus.can2, bus.can_lost}); end
    bus.prom = 1'b1;
    can_cap(16'h0001, 16'h0002);
    tick();
    can_cap(16'h0003, 16'h0004);
    tick();
    checks++; if (bus.can_lost !== 1'b0 || bus.can2 !== 1'b1) begin errors++; $display("FAIL drop_buffered got lost=%b can2=%b want 0/1", bus.can_lost, bus.can2); end
    // CPU wins this slot, so the buffered capture stays and the new one is lost.
    clear_inputs();
    cpu_req(1'b0, 16'h7777);
    can_cap(16'h0005, 16'h0006);
    bus.ovr_clr = 1'b1;
    tick();
    clear_inputs();
    checks++; if (bus.can_lost !== 1'b1 || bus.cpu1 !== 1'b1 || bus.reginp !== 16'h7777) begin errors++; $display("FAIL drop_lost got lost=%b cpu1=%b reginp=%h want 1/1/7777", bus.can_lost, bus.cpu1, bus.reginp); end
    tick();
    checks++; if (bus.can1 !== 1'b1 || bus.recidin !== 16'h0003) begin errors++; $display("FAIL drop_kept_hi got can1=%b recidin=%h want 1/0003", bus.can1, bus.recidin); end
    tick();
    checks++; if (bus.can2 !== 1'b1 || bus.recidin !== 16'h0004 || bus.can_lost !== 1'b1) begin errors++; $display("FAIL drop_kept_lo got can2=%b recidin=%h lost=%b want 1/0004/1", bus.can2, bus.recidin, bus.can_lost); end
    bus.ovr_clr = 1'b1;
    tick();
    clear_inputs();
    checks++; if (bus.can_lost !== 1'b0) begin errors++; $display("FAIL lost_clr got %b want 0", bus.can_lost); end
  endtask

  task automatic test_back_to_back();
    cpu_req(1'b1, 16'h4242);
    can_cap(16'hAAAA, 16'hBBBB);
    tick();
    clear_inputs();
    // Buffered capture is consumed this cycle, so this one is accepted.
    can_cap(16'hCCCC, 16'hDDDD);
    tick();
    clear_inputs();
    checks++; if (bus.can1 !== 1'b1 || bus.recidin !== 16'hAAAA || bus.can_lost !== 1'b0) begin errors++; $display("FAIL b2b_x_hi got can1=%b recidin=%h lost=%b want 1/aaaa/0", bus.can1, bus.recidin, bus.can_lost); end
    tick();
    checks++; if (bus.can2 !== 1'b1 || bus.recidin !== 16'hBBBB) begin errors++; $display("FAIL b2b_x_lo got can2=%b recidin=%h want 1/bbbb", bus.can2, bus.recidin); end
    tick();
    checks++; if (bus.can1 !== 1'b1 || bus.recidin !== 16'hCCCC) begin errors++; $display("FAIL b2b_y_hi got can1=%b recidin=%h want 1/cccc", bus.can1, bus.recidin); end
    tick();
    checks++; if (bus.can2 !== 1'b1 || bus.can_done !== 1'b1 || bus.recidin !== 16'hDDDD) begin errors++; $display("FAIL b2b_y_lo got can2=%b done=%b recidin=%h want 1/1/dddd", bus.can2, bus.can_done, bus.recidin); end
    tick();
    checks++; if ({bus.can1, bus.can2, bus.can_lost} !== 3'b000) begin errors++; $display("FAIL b2b_idle got can1/can2/lost=%b want 000", {bus.can1, bus.can2, bus.can_lost}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.prom = 1'b0;
    clear_inputs();
    test_reset();
    test_cpu_write();
    test_llc_capture();
    test_simultaneous();
    test_atomicity();
    test_drops();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
